// File: rtl/return_path_pkg.sv
// Shared constants and types for the slave-to-master return path.
// Tags identify which slave produced a word on the merged output stream.
package return_path_pkg;

  localparam int DEF_IDWIDTH = 1;
  localparam int DEF_DWIDTH  = 8;
  localparam int DEF_DEPTH   = 4;

  localparam logic TAG_S1 = 1'b0;
  localparam logic TAG_S2 = 1'b1;

  typedef logic [DEF_IDWIDTH+DEF_DWIDTH-1:0] tagged_word_t;

endpackage

// File: rtl/rp_fifo.sv
// Circular buffer holding tagged response words.
// Provides one write port, one read port and full/empty status decoded from the count.
module rp_fifo #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 4,
  parameter int AWIDTH = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [AWIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [AWIDTH:0]   count_q, count_d;
  logic              do_wr, do_rd;

  assign full    = (count_q == (AWIDTH+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign rd_data = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_wr    = wr_en & ~full;
    do_rd    = rd_en & ~empty;
    if (do_wr) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_rd) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_wr && !do_rd) begin
      count_d = count_q + 1'b1;
    end else if (!do_wr && do_rd) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/return_path.sv
// Merges words from two slaves into one tagged stream toward the master,
// with round-robin stop flow control, FIFO buffering and empty-FIFO bypass.
module return_path
  import return_path_pkg::*;
#(
  parameter int IDWIDTH = DEF_IDWIDTH,
  parameter int DWIDTH  = DEF_DWIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AWIDTH  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               valid1_i,
  input  logic [DWIDTH-1:0]  data1_i,
  output logic               stop1_o,
  input  logic               valid2_i,
  input  logic [DWIDTH-1:0]  data2_i,
  output logic               stop2_o,
  output logic               req_o,
  input  logic               gnt_i,
  output logic               valid_o,
  output logic [IDWIDTH-1:0] id_o,
  output logic [DWIDTH-1:0]  data_o,
  output logic               overflow_o,
  output logic               underflow_o
);

  localparam int WW = IDWIDTH + DWIDTH;

  logic          rr_q, rr_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          full, empty;
  logic          stop1, stop2, push, req, pop, bypass;
  logic          wr_en, rd_en;
  logic [WW-1:0] push_word, head_word, out_word;

  rp_fifo #(
    .WIDTH  (WW),
    .DEPTH  (DEPTH),
    .AWIDTH (AWIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (push_word),
    .rd_en   (rd_en),
    .rd_data (head_word),
    .full    (full),
    .empty   (empty)
  );

  // The round-robin pointer keeps advancing even when the favoured slave is idle.
  always_comb begin
    stop1       = full | rr_q;
    stop2       = full | ~rr_q;
    push        = (valid1_i & ~stop1) | (valid2_i & ~stop2);
    push_word   = rr_q ? {IDWIDTH'(TAG_S2), data2_i} : {IDWIDTH'(TAG_S1), data1_i};
    req         = ~empty | push;
    pop         = req & gnt_i;
    bypass      = empty & push & gnt_i;
    wr_en       = push & ~bypass;
    rd_en       = pop & ~empty;
    out_word    = '0;
    if (!empty) begin
      out_word = head_word;
    end else if (push) begin
      out_word = push_word;
    end
    rr_d        = full ? rr_q : ~rr_q;
    overflow_d  = (valid1_i & stop1) | (valid2_i & stop2);
    underflow_d = gnt_i & ~req;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q        <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Hold the interface quiet while reset is asserted, independent of register state.
  assign stop1_o        = stop1 | ~rst_n;
  assign stop2_o        = stop2 | ~rst_n;
  assign req_o          = req & rst_n;
  assign valid_o        = pop & rst_n;
  assign {id_o, data_o} = rst_n ? out_word : '0;
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

endmodule

// File: tb/tb_return_path.sv
// Randomized and directed bench for return_path, checked against a queue-based
// model of the merged stream, the round-robin turn and the error flags.
module tb_return_path;
  import return_path_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              valid1_i, valid2_i, gnt_i;
  logic [DEF_DWIDTH-1:0] data1_i, data2_i;
  logic              stop1_o, stop2_o, req_o, valid_o, overflow_o, underflow_o;
  logic [DEF_IDWIDTH-1:0] id_o;
  logic [DEF_DWIDTH-1:0]  data_o;

  int n_checks = 0;
  int n_fail   = 0;

  tagged_word_t mq[$];
  bit           turn;
  bit           m_ovf, m_udf;
  bit           e_stop1, e_stop2, e_push, e_req, e_valid;
  tagged_word_t e_pw, e_word;

  return_path dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid1_i    (valid1_i),
    .data1_i     (data1_i),
    .stop1_o     (stop1_o),
    .valid2_i    (valid2_i),
    .data2_i     (data2_i),
    .stop2_o     (stop2_o),
    .req_o       (req_o),
    .gnt_i       (gnt_i),
    .valid_o     (valid_o),
    .id_o        (id_o),
    .data_o      (data_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [14:0] act_vec();
    return {stop1_o, stop2_o, req_o, valid_o, id_o, data_o, overflow_o, underflow_o};
  endfunction

  function automatic logic [14:0] exp_vec();
    return {e_stop1, e_stop2, e_req, e_valid, e_word, m_ovf, m_udf};
  endfunction

  // Model: the slave whose turn it is may push unless the buffer is full;
  // the master sees the oldest buffered word, or the fresh word if nothing waits.
  task automatic model_eval();
    bit full, empty;
    full    = (mq.size() == DEF_DEPTH);
    empty   = (mq.size() == 0);
    e_stop1 = full || turn;
    e_stop2 = full || !turn;
    e_push  = (valid1_i && !e_stop1) || (valid2_i && !e_stop2);
    e_pw    = (valid1_i && !e_stop1) ? {TAG_S1, data1_i} : {TAG_S2, data2_i};
    e_req   = !empty || e_push;
    e_valid = e_req && gnt_i;
    if (!empty)      e_word = mq[0];
    else if (e_push) e_word = e_pw;
    else             e_word = '0;
  endtask

  task automatic model_commit();
    bit full, empty, n_ovf, n_udf;
    full  = (mq.size() == DEF_DEPTH);
    empty = (mq.size() == 0);
    n_ovf = (valid1_i && e_stop1) || (valid2_i && e_stop2);
    n_udf = gnt_i && !e_req;
    if (e_valid && !empty) void'(mq.pop_front());
    if (e_push && !(empty && gnt_i)) mq.push_back(e_pw);
    if (!full) turn = !turn;
    m_ovf = n_ovf;
    m_udf = n_udf;
  endtask

  task automatic drive(input bit v1, input logic [7:0] d1, input bit v2,
                       input logic [7:0] d2, input bit g);
    @(negedge clk);
    valid1_i = v1; data1_i = d1; valid2_i = v2; data2_i = d2; gnt_i = g;
    #1;
    model_eval();
  endtask

  task automatic hit_reset();
    @(negedge clk);
    rst_n = 1'b0;
    valid1_i = 1'b1; data1_i = 8'hAA; valid2_i = 1'b1; data2_i = 8'hBB; gnt_i = 1'b1;
    #1;
    mq.delete();
    turn = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #2;
    valid1_i = 1'b0; valid2_i = 1'b0; gnt_i = 1'b0; data1_i = '0; data2_i = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    hit_reset();
    n_checks++;
    if (act_vec() !== 15'h6000) begin
      n_fail++; $display("[TB] FAIL reset_hold got=%h exp=%h", act_vec(), 15'h6000);
    end
    release_reset();
    for (int c = 1; c <= 4; c++) begin
      drive(0, 8'h00, 0, 8'h00, 0);
      n_checks++;
      if ({stop1_o, stop2_o, req_o, overflow_o, underflow_o} !== ((c % 2 == 1) ? 5'b01000 : 5'b10000)) begin
        n_fail++; $display("[TB] FAIL reset_idle_c%0d got=%b", c, {stop1_o, stop2_o, req_o, overflow_o, underflow_o});
      end
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL reset_idle_vec got=%h exp=%h", act_vec(), exp_vec());
      end
      model_commit();
    end
  endtask

  task automatic test_bypass();
    if (turn) begin drive(0, 8'h00, 0, 8'h00, 0); model_commit(); end
    drive(1, 8'h5A, 0, 8'h00, 1);
    n_checks++;
    if ({valid_o, id_o, data_o} !== {1'b1, 1'b0, 8'h5A}) begin
      n_fail++; $display("[TB] FAIL bypass_word got=%b/%0d/%h exp=1/0/5a", valid_o, id_o, data_o);
    end
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("[TB] FAIL bypass_vec got=%h exp=%h", act_vec(), exp_vec());
    end
    model_commit();
    drive(0, 8'h00, 0, 8'h00, 0);
    n_checks++;
    if (req_o !== 1'b0) begin
      n_fail++; $display("[TB] FAIL bypass_not_stored got=%b exp=0", req_o);
    end
    model_commit();
  endtask

  task automatic test_fill_drain();
    logic [7:0] tbl [4];
    tbl = '{8'h11, 8'h22, 8'h33, 8'h44};
    if (turn) begin drive(0, 8'h00, 0, 8'h00, 0); model_commit(); end
    for (int i = 0; i < 4; i++) begin
      drive(i % 2 == 0, tbl[i], i % 2 == 1, tbl[i], 0);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL fill_vec%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
      model_commit();
    end
    drive(0, 8'h00, 0, 8'h00, 0);
    n_checks++;
    if ({stop1_o, stop2_o, req_o} !== 3'b111) begin
      n_fail++; $display("[TB] FAIL fill_full got=%b exp=111", {stop1_o, stop2_o, req_o});
    end
    model_commit();
    for (int k = 0; k < 4; k++) begin
      drive(0, 8'h00, 0, 8'h00, 1);
      n_checks++;
      if ({valid_o, id_o, data_o} !== {1'b1, k[0], tbl[k]}) begin
        n_fail++; $display("[TB] FAIL drain_word%0d got=%b/%0d/%h exp=1/%0d/%h", k, valid_o, id_o, data_o, k % 2, tbl[k]);
      end
      if (k == 1) begin
        n_checks++;
        if ((stop1_o ^ stop2_o) !== 1'b1) begin
          n_fail++; $display("[TB] FAIL drain_reopen got=%b%b exp=one low", stop1_o, stop2_o);
        end
      end
      model_commit();
    end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 4; i++) begin
      drive(!turn, 8'($urandom), turn, 8'($urandom), 0);
      model_commit();
    end
    drive(0, 8'h00, 0, 8'h00, 1);
    n_checks++;
    if ({stop1_o, stop2_o, valid_o} !== 3'b111) begin
      n_fail++; $display("[TB] FAIL fullpop_stops got=%b exp=111", {stop1_o, stop2_o, valid_o});
    end
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("[TB] FAIL fullpop_vec got=%h exp=%h", act_vec(), exp_vec());
    end
    model_commit();
    drive(0, 8'h00, 0, 8'h00, 0);
    n_checks++;
    if ({stop1_o ^ stop2_o, req_o} !== 2'b11) begin
      n_fail++; $display("[TB] FAIL fullpop_reopen got=%b%b%b exp=one stop low, req", stop1_o, stop2_o, req_o);
    end
    model_commit();
    for (int i = 0; i < 8 && mq.size() > 0; i++) begin
      drive(0, 8'h00, 0, 8'h00, 1);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL fullpop_drain got=%h exp=%h", act_vec(), exp_vec());
      end
      model_commit();
    end
  endtask

  task automatic test_errors();
    if (turn) begin drive(0, 8'h00, 0, 8'h00, 0); model_commit(); end
    drive(0, 8'h00, 1, 8'h77, 0);
    n_checks++;
    if ({stop2_o, req_o} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL ovf_ignored got=%b exp=10", {stop2_o, req_o});
    end
    model_commit();
    drive(0, 8'h00, 0, 8'h00, 0);
    n_checks++;
    if ({overflow_o, req_o} !== 2'b10) begin
      n_fail++; $display("[TB] FAIL ovf_flag got=%b exp=10", {overflow_o, req_o});
    end
    model_commit();
    drive(0, 8'h00, 0, 8'h00, 1);
    n_checks++;
    if ({overflow_o, valid_o} !== 2'b00) begin
      n_fail++; $display("[TB] FAIL ovf_pulse got=%b exp=00", {overflow_o, valid_o});
    end
    model_commit();
    drive(0, 8'h00, 0, 8'h00, 0);
    n_checks++;
    if (underflow_o !== 1'b1) begin
      n_fail++; $display("[TB] FAIL udf_flag got=%b exp=1", underflow_o);
    end
    model_commit();
    drive(0, 8'h00, 0, 8'h00, 0);
    n_checks++;
    if (act_vec() !== exp_vec()) begin
      n_fail++; $display("[TB] FAIL udf_clear got=%h exp=%h", act_vec(), exp_vec());
    end
    model_commit();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(!turn, 8'hE0 + 8'(i), turn, 8'hE0 + 8'(i), 0);
      model_commit();
    end
    hit_reset();
    n_checks++;
    if (act_vec() !== 15'h6000) begin
      n_fail++; $display("[TB] FAIL midreset_hold got=%h exp=%h", act_vec(), 15'h6000);
    end
    release_reset();
    for (int i = 0; i < 5; i++) begin
      drive(0, 8'h00, 0, 8'h00, 1);
      n_checks++;
      if ({req_o, valid_o, data_o} !== 10'b0) begin
        n_fail++; $display("[TB] FAIL midreset_stale got=%b/%b/%h exp=0/0/00", req_o, valid_o, data_o);
      end
      model_commit();
    end
    drive(!turn, 8'hC3, turn, 8'hC3, 1);
    n_checks++;
    if ({valid_o, data_o} !== {1'b1, 8'hC3}) begin
      n_fail++; $display("[TB] FAIL midreset_fresh got=%b/%h exp=1/c3", valid_o, data_o);
    end
    model_commit();
  endtask

  task automatic test_random();
    bit full, s1, s2, v1, v2, g, will_req;
    for (int i = 0; i < 600; i++) begin
      full = (mq.size() == DEF_DEPTH);
      s1 = full || turn;
      s2 = full || !turn;
      v1 = ($urandom_range(0, 2) != 0) && (!s1 || $urandom_range(0, 15) == 0);
      v2 = ($urandom_range(0, 2) != 0) && (!s2 || $urandom_range(0, 15) == 0);
      will_req = (mq.size() != 0) || (v1 && !s1) || (v2 && !s2);
      if (will_req) g = ((i / 60) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      else          g = ($urandom_range(0, 19) == 0);
      drive(v1, 8'($urandom), v2, 8'($urandom), g);
      n_checks++;
      if (act_vec() !== exp_vec()) begin
        n_fail++; $display("[TB] FAIL random_c%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
      model_commit();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    valid1_i = 1'b0; valid2_i = 1'b0; gnt_i = 1'b0; data1_i = '0; data2_i = '0;
    mq.delete(); turn = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    test_reset();
    test_bypass();
    test_fill_drain();
    test_full_pop();
    test_errors();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
